// File: rtl/clk_strobe_pkg.sv
// clk_strobe_pkg: shared default divider and counter-width helper for clk_strobe.
package clk_strobe_pkg;
  localparam int DIV_DEFAULT = 128;
  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/clk_strobe.sv
// clk_strobe: one-cycle strobe every DIV clocks; CLK_STROBE_HALF_EN adds a mid-period strobe_half.
module clk_strobe
  import clk_strobe_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic strobe
`ifdef CLK_STROBE_HALF_EN
  ,
  output logic strobe_half
`endif
);
  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt, cnt_nxt;
  if (DIV < 1) begin : g_bad_div
    $error("clk_strobe: DIV must be >= 1");
  end
  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      strobe <= (cnt == LAST);
    end
  end
`ifdef CLK_STROBE_HALF_EN
  localparam logic [W-1:0] HALF = W'(DIV / 2);
  // keyed on the next count so the pulse lands on the edge where cnt becomes DIV/2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) strobe_half <= 1'b0;
    else strobe_half <= (cnt_nxt == HALF);
  end
`endif
endmodule

// File: tb/tb_clk_strobe.sv
// tb_clk_strobe: scoreboard bench for clk_strobe at DIV=128, 5 and 1.
module tb_clk_strobe;
  logic clk = 1'b0;
  logic rst_128, rst_5, rst_1;
  logic s128, s5, s1;
  int k_128 = 0, k_5 = 0, k_1 = 0;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic s128, s5, s1, h128, h5, h1;
    logic [2:0] c5;
  } exp_t;
  exp_t q[$];
`ifdef CLK_STROBE_HALF_EN
  logic h128, h5, h1;
  clk_strobe #(.DIV(128)) u128 (.clk(clk), .reset(rst_128), .strobe(s128), .strobe_half(h128));
  clk_strobe #(.DIV(5))   u5   (.clk(clk), .reset(rst_5),   .strobe(s5),   .strobe_half(h5));
  clk_strobe #(.DIV(1))   u1   (.clk(clk), .reset(rst_1),   .strobe(s1),   .strobe_half(h1));
`else
  clk_strobe #(.DIV(128)) u128 (.clk(clk), .reset(rst_128), .strobe(s128));
  clk_strobe #(.DIV(5))   u5   (.clk(clk), .reset(rst_5),   .strobe(s5));
  clk_strobe #(.DIV(1))   u1   (.clk(clk), .reset(rst_1),   .strobe(s1));
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // drive happens before entry (at negedge); model predicts the coming edge, then compares
  task automatic cycle();
    exp_t e;
    k_128 = rst_128 ? k_128 + 1 : 0;
    k_5   = rst_5 ? k_5 + 1 : 0;
    k_1   = rst_1 ? k_1 + 1 : 0;
    e.s128 = rst_128 && (k_128 % 128 == 0);
    e.h128 = rst_128 && (k_128 % 128 == 64);
    e.s5   = rst_5 && (k_5 % 5 == 0);
    e.h5   = rst_5 && (k_5 % 5 == 2);
    e.c5   = 3'(k_5 % 5);
    e.s1   = rst_1;
    e.h1   = rst_1;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("strobe128", 32'(s128), 32'(e.s128));
    check("strobe5", 32'(s5), 32'(e.s5));
    check("strobe1", 32'(s1), 32'(e.s1));
    check("cnt5", 32'(u5.cnt), 32'(e.c5));
`ifdef CLK_STROBE_HALF_EN
    check("half128", 32'(h128), 32'(e.h128));
    check("half5", 32'(h5), 32'(e.h5));
    check("half1", 32'(h1), 32'(e.h1));
`endif
    @(negedge clk);
  endtask
  initial begin
    rst_128 = 1'b0;
    rst_5 = 1'b0;
    rst_1 = 1'b0;
    #1;
    check("rst_strobe128", 32'(s128), 0);
    check("rst_cnt128", 32'(u128.cnt), 0);
    @(negedge clk);
    repeat (3) cycle();
    rst_128 = 1'b1;
    rst_5 = 1'b1;
    rst_1 = 1'b1;
    repeat (10 * 128 + 5) cycle();
    rst_128 = 1'b0;
    cycle();
    rst_128 = 1'b1;
    repeat (70) cycle();
    rst_128 = 1'b0;
    repeat (5) cycle();
    rst_128 = 1'b1;
    repeat (130) cycle();
    rst_128 = 1'b0;
    rst_5 = 1'b0;
    rst_1 = 1'b0;
    cycle();
    rst_128 = 1'b1;
    rst_5 = 1'b1;
    rst_1 = 1'b1;
    repeat (128) cycle();
    check("pre_async_strobe128", 32'(s128), 1);
    check("pre_async_strobe1", 32'(s1), 1);
    check("pre_async_cnt5", 32'(u5.cnt), 3);
    rst_128 = 1'b0;
    rst_5 = 1'b0;
    rst_1 = 1'b0;
    #1;
    check("async_strobe128", 32'(s128), 0);
    check("async_cnt128", 32'(u128.cnt), 0);
    check("async_strobe1", 32'(s1), 0);
    check("async_cnt5", 32'(u5.cnt), 0);
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
